led_blink_arbiter: RTL and testbench

Round-robin arbiter and blink-code sequencer that shares the single on-board PIN13_LED between three requesters on the XLR8 board. Each requester asks for an N-blink code. The block grants one requester at a time, plays the code with fixed on/off/gap timing derived from the 16 MHz CLOCK, and signals completion. When no code is playing, it drives a free-running heartbeat on the LED.

---
 rtl/led_blink_arbiter.sv | 150 +++++++++++++++
 tb/tb_led_blink_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/led_blink_arbiter.sv
// Shares one LED between three requesters: round-robin grant, then plays an
// N-blink code with tick-based on/off/gap timing; heartbeat shown while idle.
module led_blink_arbiter #(
  parameter int unsigned TICK_DIV  = 800000,
  parameter int unsigned ON_TICKS  = 6,
  parameter int unsigned OFF_TICKS = 6,
  parameter int unsigned GAP_TICKS = 20,
  parameter int unsigned HB_BIT    = 20
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic [2:0] req,
  input  logic [3:0] cnt0,
  input  logic [3:0] cnt1,
  input  logic [3:0] cnt2,
  output logic [2:0] grant,
  output logic [2:0] done,
  output logic       busy,
  output logic       led
);

  localparam int unsigned    PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]  PRESC_PRE = PW'(TICK_DIV - 2);
  localparam logic [7:0]     ON_LAST   = 8'(ON_TICKS - 1);
  localparam logic [7:0]     OFF_LAST  = 8'(OFF_TICKS - 1);
  localparam logic [7:0]     GAP_LAST  = 8'(GAP_TICKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [7:0]     phase_q, phase_d;
  logic [31:0]    hb_cnt_q, hb_cnt_d;
  logic [1:0]     last_q, last_d;
  logic [3:0]     blinks_q, blinks_d;
  logic [2:0]     grant_q, grant_d;
  logic [2:0]     done_q, done_d;
  logic           busy_q, busy_d;
  logic           led_q, led_d;

  logic           tick;
  logic [1:0]     win;
  logic [3:0]     cnt_sel;

  // Candidates are scanned last+3 down to last+1 so the nearest one wins.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [2:0] s;
    logic [1:0] idx;
    rr_pick = 2'd0;
    for (int k = 3; k >= 1; k--) begin
      s   = {1'b0, last} + 3'(k);
      idx = (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign tick = (presc_q == PRESC_MAX);
  assign win  = rr_pick(req, last_q);

  always_comb begin
    case (win)
      2'd0:    cnt_sel = cnt0;
      2'd1:    cnt_sel = cnt1;
      default: cnt_sel = cnt2;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    presc_d  = tick ? '0 : presc_q + PW'(1);
    phase_d  = phase_q + 8'(tick);
    hb_cnt_d = hb_cnt_q + 32'd1;
    last_d   = last_q;
    blinks_d = blinks_q;
    grant_d  = grant_q;
    done_d   = 3'b000;

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          last_d   = win;
          grant_d  = 3'b001 << win;
          blinks_d = cnt_sel;
          state_d  = (cnt_sel != 4'd0) ? S_ON : S_GAP;
        end
      end
      S_ON: begin
        if (tick && phase_q == ON_LAST) begin
          blinks_d = blinks_q - 4'd1;
          state_d  = S_OFF;
        end
      end
      S_OFF: begin
        if (tick && phase_q == OFF_LAST)
          state_d = (blinks_q != 4'd0) ? S_ON : S_GAP;
      end
      S_GAP: begin
        // done is registered, so raise it one cycle ahead of the final tick
        if (presc_q == PRESC_PRE && phase_q == GAP_LAST)
          done_d = grant_q;
        if (tick && phase_q == GAP_LAST) begin
          state_d = S_IDLE;
          grant_d = 3'b000;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      presc_d = '0;
      phase_d = 8'd0;
    end

    busy_d = |grant_d;
    led_d  = (state_d == S_ON) || (state_d == S_IDLE && hb_cnt_d[HB_BIT]);
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      phase_q  <= 8'd0;
      hb_cnt_q <= 32'd0;
      last_q   <= 2'd2;
      blinks_q <= 4'd0;
      grant_q  <= 3'b000;
      done_q   <= 3'b000;
      busy_q   <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      phase_q  <= phase_d;
      hb_cnt_q <= hb_cnt_d;
      last_q   <= last_d;
      blinks_q <= blinks_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      led_q    <= led_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign led   = led_q;

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Directed bench for led_blink_arbiter with short timing (4-cycle tick, 2/2/3 ticks).
module tb_led_blink_arbiter;
  localparam int HB = 2;

  logic       CLOCK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [2:0] req;
  logic [3:0] cnt0, cnt1, cnt2;
  logic [2:0] grant, done;
  logic       busy, led;
  logic [31:0] hb;
  int checks = 0;
  int errors = 0;

  always #5 CLOCK = ~CLOCK;

  // Reference heartbeat: cycles elapsed since reset release
  always @(posedge CLOCK or negedge RESET_N)
    if (!RESET_N) hb <= 32'd0;
    else          hb <= hb + 32'd1;

  led_blink_arbiter #(
    .TICK_DIV(4), .ON_TICKS(2), .OFF_TICKS(2), .GAP_TICKS(3), .HB_BIT(HB)
  ) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .req(req),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2),
    .grant(grant), .done(done), .busy(busy), .led(led)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_grant(input logic [2:0] exp);
    int n = 0;
    do begin
      @(negedge CLOCK);
      n++;
    end while (grant == 3'b000 && n < 6);
    chk("grant_start", 32'(grant), 32'(exp));
  endtask

  // Checks a whole sequence from its first busy cycle through the idle cycle after it.
  task automatic run_seq(input logic [2:0] own, input int cnt, input int drop_i);
    int b;
    b = (cnt * 4 + 3) * 4;
    for (int i = 0; i < b; i++) begin
      if (i > 0) @(negedge CLOCK);
      chk("grant", 32'(grant), 32'(own));
      chk("busy", 32'(busy), 32'd1);
      chk("led", 32'(led), 32'((i < cnt * 16) && ((i % 16) < 8)));
      chk("done", 32'(done), (i == b - 1) ? 32'(own) : 32'd0);
      if (i == drop_i) begin
        req  = 3'b000;
        cnt0 = 4'hf; cnt1 = 4'hf; cnt2 = 4'hf;
      end
    end
    @(negedge CLOCK);
    chk("idle_grant", 32'(grant), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_led", 32'(led), 32'(hb[HB]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    req = 3'b000; cnt0 = 4'd0; cnt1 = 4'd0; cnt2 = 4'd0;
    #2;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    repeat (2) @(negedge CLOCK);
    RESET_N = 1'b1;

    // Idle heartbeat, no requests
    for (int i = 0; i < 20; i++) begin
      @(negedge CLOCK);
      chk("hb_grant", 32'(grant), 32'd0);
      chk("hb_done", 32'(done), 32'd0);
      chk("hb_led", 32'(led), 32'(hb[HB]));
    end

    // req0 pulsed, two blinks
    cnt0 = 4'd2; req = 3'b001;
    wait_grant(3'b001);
    run_seq(3'b001, 2, 0);

    // zero-count code goes straight to the gap
    cnt1 = 4'd0; req = 3'b010;
    wait_grant(3'b010);
    run_seq(3'b010, 0, 0);

    // req2 dropped after one cycle, cnt2 changed mid-sequence
    cnt2 = 4'd3; req = 3'b100;
    wait_grant(3'b100);
    run_seq(3'b100, 3, 1);

    // all three held: round-robin with one idle cycle between grants
    cnt0 = 4'd1; cnt1 = 4'd1; cnt2 = 4'd1; req = 3'b111;
    wait_grant(3'b001);
    run_seq(3'b001, 1, -1);
    @(negedge CLOCK); chk("rr_second", 32'(grant), 32'b010);
    run_seq(3'b010, 1, -1);
    @(negedge CLOCK); chk("rr_third", 32'(grant), 32'b100);
    run_seq(3'b100, 1, -1);
    @(negedge CLOCK); chk("rr_wrap", 32'(grant), 32'b001);
    run_seq(3'b001, 1, -1);
    req = 3'b000;

    // reset in the middle of a sequence
    cnt0 = 4'd2; req = 3'b001;
    wait_grant(3'b001);
    repeat (10) @(negedge CLOCK);
    #1 RESET_N = 1'b0;
    #1;
    chk("abort_led", 32'(led), 32'd0);
    chk("abort_grant", 32'(grant), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    req = 3'b000;
    @(negedge CLOCK);
    chk("abort_done_hold", 32'(done), 32'd0);
    RESET_N = 1'b1;

    // round-robin pointer restarts so requester 0 beats requester 1
    cnt0 = 4'd1; cnt1 = 4'd1; req = 3'b011;
    wait_grant(3'b001);
    #1 RESET_N = 1'b0;
    req = 3'b000;
    @(negedge CLOCK);
    RESET_N = 1'b1;

    // requester 1 alone after reset
    cnt1 = 4'd0; req = 3'b010;
    wait_grant(3'b010);
    run_seq(3'b010, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
